// File: rtl/ram_march_pkg.sv
// Shared types and pattern helper for the RAM march initiator.
// Holds the FSM state enum and the seed-xor-address test pattern.
package ram_march_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int ERR_W = ADDR_WIDTH + 2;
  // Wide enough for any legal word size; callers cast down.
  localparam int PAT_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    DR0,
    WR1,
    RD1,
    DR1,
    FIN
  } march_state_e;

  function automatic logic [PAT_W-1:0] pattern(
    input logic [PAT_W-1:0] addr,
    input logic             inv,
    input logic [PAT_W-1:0] seed
  );
    logic [PAT_W-1:0] p;
    p = seed ^ addr;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_march_cmp_pipe.sv
// Read-return compare pipeline for the march initiator.
// Delays {valid, addr, expected} to meet rd_data and counts mismatches.
module ram_march_cmp_pipe #(
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push_vld,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_exp,
  input  logic [DW-1:0] rd_data,
  output logic          hit,
  output logic [AW+1:0] err_count,
  output logic [AW-1:0] first_err_addr
);

  logic [LAT-1:0] vld;
  logic [AW-1:0]  addr_q [LAT];
  logic [DW-1:0]  exp_q  [LAT];

  assign hit = vld[LAT-1] && (rd_data != exp_q[LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld            <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      for (int i = 0; i < LAT; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld[0]    <= push_vld;
      addr_q[0] <= push_addr;
      exp_q[0]  <= push_exp;
      for (int i = 1; i < LAT; i++) begin
        vld[i]    <= vld[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
      if (clr) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (hit) begin
        // A zero count means this is the first mismatch of the run.
        if (err_count == '0)
          first_err_addr <= addr_q[LAT-1];
        if (err_count != '1)
          err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_march_initiator.sv
// Two-pass march test initiator for a simple synchronous RAM.
// Writes P(a), checks it, writes ~P(a), checks it, then reports.
module ram_march_initiator #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_SIZE  = 4,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] SEED       = 32'hA5C3_0F96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_WIDTH+1:0]     err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [8*DATA_SIZE-1:0]    rd_data,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [8*DATA_SIZE-1:0]    wr_data
);

  import ram_march_pkg::*;

  localparam int DW = 8 * DATA_SIZE;
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [LW-1:0] DR_LAST = LW'(RD_LATENCY - 1);

  march_state_e state;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [LW-1:0]         dr_cnt;
  logic                  push_vld;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DW-1:0]         push_exp;
  logic                  hit;
  logic                  accept;
  logic                  inv;

  // The done cycle is already IDLE; a start there is still ignored.
  assign accept = (state == IDLE) && start && !done;
  assign inv    = (state == WR1) || (state == RD1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dr_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      push_vld  <= 1'b0;
      push_addr <= '0;
      push_exp  <= '0;
    end else begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      push_vld <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= WR0;
            busy  <= 1'b1;
            pass  <= 1'b0;
            cnt   <= '0;
          end
        end
        WR0, WR1: begin
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= DW'(pattern(PAT_W'(cnt), inv, PAT_W'(SEED)));
          cnt     <= cnt + 1'b1;
          if (cnt == LAST)
            state <= (state == WR0) ? RD0 : RD1;
        end
        RD0, RD1: begin
          rd_en     <= 1'b1;
          rd_addr   <= cnt;
          push_vld  <= 1'b1;
          push_addr <= cnt;
          push_exp  <= DW'(pattern(PAT_W'(cnt), inv, PAT_W'(SEED)));
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= (state == RD0) ? DR0 : DR1;
            dr_cnt <= '0;
          end
        end
        DR0, DR1: begin
          if (dr_cnt == DR_LAST)
            state <= (state == DR0) ? WR1 : FIN;
          else
            dr_cnt <= dr_cnt + 1'b1;
        end
        FIN: begin
          // The last read-back is compared on this very edge.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0) && !hit;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_march_cmp_pipe #(
    .AW  (ADDR_WIDTH),
    .DW  (DW),
    .LAT (RD_LATENCY)
  ) u_cmp (
    .clk            (clk),
    .rst            (rst),
    .clr            (accept),
    .push_vld       (push_vld),
    .push_addr      (push_addr),
    .push_exp       (push_exp),
    .rd_data        (rd_data),
    .hit            (hit),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_ram_march_initiator.sv
// Directed bench for ram_march_initiator with behavioural RAM models.
// Covers latency 1 (with fault injection) and latency 3.
module tb_ram_march_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fault = 0;
  int both_a = 0;
  int both_b = 0;

  logic       start_a, busy_a, done_a, pass_a, rd_en_a, wr_en_a;
  logic [7:0] err_a;
  logic [5:0] fea_a, rd_addr_a, wr_addr_a;
  logic [31:0] rd_data_a, wr_data_a;

  logic       start_b, busy_b, done_b, pass_b, rd_en_b, wr_en_b;
  logic [7:0] err_b;
  logic [5:0] fea_b, rd_addr_b, wr_addr_b;
  logic [31:0] rd_data_b, wr_data_b;

  ram_march_initiator #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_addr(fea_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  ram_march_initiator #(.RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_addr(fea_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  // Latency-1 RAM with optional fault injection on the return path.
  logic [31:0] mem_a [64];
  logic [31:0] q_a;
  logic [5:0]  qa_addr;
  always @(posedge clk) begin
    if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
    if (rd_en_a) begin
      q_a     <= mem_a[rd_addr_a];
      qa_addr <= rd_addr_a;
    end
  end
  assign rd_data_a = (fault == 1 && qa_addr == 6'd17) ? (q_a ^ 32'd1) :
                     (fault == 2) ? (q_a & 32'h7FFF_FFFF) : q_a;

  // Latency-3 RAM.
  logic [31:0] mem_b [64];
  logic [31:0] q1_b, q2_b, q3_b;
  always @(posedge clk) begin
    if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
    if (rd_en_b) q1_b <= mem_b[rd_addr_b];
    q2_b <= q1_b;
    q3_b <= q2_b;
  end
  assign rd_data_b = q3_b;

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(rd_en_a && wr_en_a));
      assert (!(rd_en_b && wr_en_b));
      if (rd_en_a && wr_en_a) both_a++;
      if (rd_en_b && wr_en_b) both_b++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_a(input string tag, input bit proto,
                       input logic [7:0] e_err, input logic [5:0] e_fea,
                       input bit e_pass);
    int dk;
    int nd;
    logic bd;
    dk = -1;
    nd = 0;
    bd = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, "_busy0"}, busy_a, 1);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start_a = proto && (k == 40 || k == 259);
      if (k == 4)
        chk({tag, "_wbus3"}, {rd_en_a, wr_en_a, wr_addr_a, wr_data_a},
            {1'b0, 1'b1, 6'd3, 32'hA5C3_0F95});
      if (k == 65)
        chk({tag, "_rbus0"}, {rd_en_a, wr_en_a, rd_addr_a},
            {1'b1, 1'b0, 6'd0});
      if (done_a) begin
        nd++;
        if (dk < 0) begin
          dk = k;
          bd = busy_a;
        end
      end
    end
    start_a = 1'b0;
    chk({tag, "_done_at"}, dk, 259);
    chk({tag, "_busy_done"}, bd, 0);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_busy_end"}, busy_a, 0);
    chk({tag, "_pass"}, pass_a, e_pass);
    chk({tag, "_err"}, err_a, e_err);
    chk({tag, "_fea"}, fea_a, e_fea);
  endtask

  initial begin
    int nd;
    int dk;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a",
        {busy_a, done_a, pass_a, rd_en_a, wr_en_a, err_a, fea_a}, 0);
    chk("rst_outs_b",
        {busy_b, done_b, pass_b, rd_en_b, wr_en_b, err_b, fea_b}, 0);
    rst = 1'b0;
    repeat (7) @(negedge clk);

    run_a("clean", 1'b1, 8'd0, 6'd0, 1'b1);
    fault = 1;
    run_a("flt17", 1'b0, 8'd2, 6'd17, 1'b0);
    fault = 2;
    run_a("stuck31", 1'b0, 8'd64, 6'd0, 1'b0);
    fault = 0;

    // Reset in the middle of RD0.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (90) @(negedge clk);
    chk("mid_rd_en", rd_en_a, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs",
        {busy_a, done_a, pass_a, rd_en_a, wr_en_a, err_a, fea_a,
         rd_addr_a, wr_addr_a, wr_data_a}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("mid_no_done", nd, 0);
    run_a("again", 1'b0, 8'd0, 6'd0, 1'b1);

    // Latency 3 variant.
    dk = -1;
    nd = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_b) begin
        nd++;
        if (dk < 0) dk = k;
      end
    end
    chk("lat3_done_at", dk, 263);
    chk("lat3_ndone", nd, 1);
    chk("lat3_pass", pass_b, 1);
    chk("lat3_err", err_b, 0);
    chk("lat3_fea", fea_b, 0);

    chk("excl_a", both_a, 0);
    chk("excl_b", both_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
